// File: rtl/controller.sv
// Multicycle MIPS-style main controller.
// Moore FSM steps each instruction through fetch, decode and execution phases;
// state-dependent outputs are registered alongside the state, so they are
// glitch-free and take their fetch values the moment reset asserts.
// pcen and alucontrol are the only combinational outputs: pcen folds in the
// ALU zero flag for branches, and alucontrol decodes the internal ALU op class
// together with the R-type function field.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    BNEBR    = 4'd9,
    ADDIEXEC = 4'd10,
    ADDIWB   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  state_t     state;
  state_t     next_state;

  // Internal registered controls that only feed pcen / alucontrol.
  logic       pcwrite;
  logic       branch;
  logic       bne;
  logic [1:0] aluop;

  // Output values belonging to the state about to be entered.
  logic       pcwrite_next;
  logic       branch_next;
  logic       bne_next;
  logic [1:0] aluop_next;
  logic       memwrite_next;
  logic       irwrite_next;
  logic       regwrite_next;
  logic       alusrca_next;
  logic       iord_next;
  logic       memtoreg_next;
  logic       regdst_next;
  logic [1:0] alusrcb_next;
  logic [1:0] pcsrc_next;

  // Next-state selection; unknown opcodes and stray encodings fall back to FETCH.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_BNE:       next_state = BNEBR;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    next_state = MEMWB;
      EXECUTE:  next_state = ALUWB;
      ADDIEXEC: next_state = ADDIWB;
      default:  next_state = FETCH;
    endcase
  end

  // Moore output decode for the upcoming state; anything not set stays 0.
  always_comb begin
    pcwrite_next  = 1'b0;
    branch_next   = 1'b0;
    bne_next      = 1'b0;
    aluop_next    = 2'b00;
    memwrite_next = 1'b0;
    irwrite_next  = 1'b0;
    regwrite_next = 1'b0;
    alusrca_next  = 1'b0;
    iord_next     = 1'b0;
    memtoreg_next = 1'b0;
    regdst_next   = 1'b0;
    alusrcb_next  = 2'b00;
    pcsrc_next    = 2'b00;
    case (next_state)
      FETCH: begin
        alusrcb_next = 2'b01;
        irwrite_next = 1'b1;
        pcwrite_next = 1'b1;
      end
      DECODE: begin
        alusrcb_next = 2'b11;
      end
      MEMADR, ADDIEXEC: begin
        alusrca_next = 1'b1;
        alusrcb_next = 2'b10;
      end
      MEMRD: begin
        iord_next = 1'b1;
      end
      MEMWR: begin
        iord_next     = 1'b1;
        memwrite_next = 1'b1;
      end
      MEMWB: begin
        memtoreg_next = 1'b1;
        regwrite_next = 1'b1;
      end
      EXECUTE: begin
        alusrca_next = 1'b1;
        aluop_next   = 2'b10;
      end
      ALUWB: begin
        regdst_next   = 1'b1;
        regwrite_next = 1'b1;
      end
      ADDIWB: begin
        regwrite_next = 1'b1;
      end
      BRANCH: begin
        alusrca_next = 1'b1;
        aluop_next   = 2'b01;
        pcsrc_next   = 2'b01;
        branch_next  = 1'b1;
      end
      BNEBR: begin
        alusrca_next = 1'b1;
        aluop_next   = 2'b01;
        pcsrc_next   = 2'b01;
        bne_next     = 1'b1;
      end
      JUMP: begin
        pcsrc_next   = 2'b10;
        pcwrite_next = 1'b1;
      end
      default: begin
        pcwrite_next = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset loads FETCH and its outputs at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pcwrite  <= 1'b1;
      branch   <= 1'b0;
      bne      <= 1'b0;
      aluop    <= 2'b00;
      memwrite <= 1'b0;
      irwrite  <= 1'b1;
      regwrite <= 1'b0;
      alusrca  <= 1'b0;
      iord     <= 1'b0;
      memtoreg <= 1'b0;
      regdst   <= 1'b0;
      alusrcb  <= 2'b01;
      pcsrc    <= 2'b00;
    end else begin
      state    <= next_state;
      pcwrite  <= pcwrite_next;
      branch   <= branch_next;
      bne      <= bne_next;
      aluop    <= aluop_next;
      memwrite <= memwrite_next;
      irwrite  <= irwrite_next;
      regwrite <= regwrite_next;
      alusrca  <= alusrca_next;
      iord     <= iord_next;
      memtoreg <= memtoreg_next;
      regdst   <= regdst_next;
      alusrcb  <= alusrcb_next;
      pcsrc    <= pcsrc_next;
    end
  end

  // PC enable: unconditional writes plus taken beq / bne.
  always_comb begin
    pcen = pcwrite | (branch & zero) | (bne & ~zero);
  end

  // ALU control: fixed add/sub for address and branch work, funct for R-type.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Randomized bench for the multicycle controller. A per-instruction reference
// model lists, for every cycle counted from FETCH, what the datapath controls
// must be; outputs are sampled 1 time unit after each falling edge.
module tb_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  int tests_run;
  int tests_failed;

  controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: pcen memwrite irwrite regwrite alusrca iord memtoreg regdst alusrcb pcsrc alucontrol
  function automatic logic [14:0] observed();
    return {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
            alusrcb, pcsrc, alucontrol};
  endfunction

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b (pcen mw irw rw asa iord m2r rdst asb pcs alu)",
               tag, got, exp);
    end
  endtask

  // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 beq, 4 bne, 5 addi, 6 j, 7 unknown.
  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return 2;
      6'b000100: return 3;
      6'b000101: return 4;
      6'b001000: return 5;
      6'b000010: return 6;
      default:   return 7;
    endcase
  endfunction

  // Cycles spent from FETCH until FETCH is seen again.
  function automatic int latency(input int cls);
    case (cls)
      0:       return 5;
      1, 2, 5: return 4;
      3, 4, 6: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected controls in cycle k of an instruction (k = 0 is the fetch cycle).
  function automatic logic [14:0] model(input logic [5:0] o, input logic [5:0] f,
                                        input int k, input logic z);
    logic e_pcen, e_mw, e_irw, e_rw, e_asa, e_iord, e_m2r, e_rdst;
    logic [1:0] e_asb, e_pcs;
    logic [2:0] e_alu;
    int cls;
    cls = classify(o);
    {e_pcen, e_mw, e_irw, e_rw, e_asa, e_iord, e_m2r, e_rdst} = 8'b0;
    e_asb = 2'b00;
    e_pcs = 2'b00;
    e_alu = 3'b010;
    if (k == 0) begin
      e_pcen = 1'b1; e_irw = 1'b1; e_asb = 2'b01;
    end else if (k == 1) begin
      e_asb = 2'b11;
    end else begin
      case (cls)
        0, 1, 5: begin
          if (k == 2) begin
            e_asa = 1'b1; e_asb = 2'b10;
          end else if (cls == 0 && k == 3) begin
            e_iord = 1'b1;
          end else if (cls == 0) begin
            e_m2r = 1'b1; e_rw = 1'b1;
          end else if (cls == 1) begin
            e_iord = 1'b1; e_mw = 1'b1;
          end else begin
            e_rw = 1'b1;
          end
        end
        2: begin
          if (k == 2) begin
            e_asa = 1'b1; e_alu = rtype_alu(f);
          end else begin
            e_rdst = 1'b1; e_rw = 1'b1;
          end
        end
        3, 4: begin
          e_asa = 1'b1; e_pcs = 2'b01; e_alu = 3'b110;
          e_pcen = (cls == 3) ? z : ~z;
        end
        6: begin
          e_pcs = 2'b10; e_pcen = 1'b1;
        end
        default: ;
      endcase
    end
    return {e_pcen, e_mw, e_irw, e_rw, e_asa, e_iord, e_m2r, e_rdst, e_asb, e_pcs, e_alu};
  endfunction

  // Runs one instruction; if abort_k >= 0, reset is pulsed mid-cycle at that step.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_k);
    int len;
    len = latency(classify(o));
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op    = o;
        funct = f;
      end
      zero = 1'($urandom);
      #1;
      check($sformatf("op%b_f%b_k%0d_z%0d", o, f, k, zero), observed(), model(o, f, k, zero));
      if (k == abort_k) begin
        #1 reset = 1'b1;
        #1;
        check($sformatf("rst_mid_op%b_k%0d", o, k), observed(), model(o, f, 0, zero));
        @(posedge clk);
        #1;
        check("rst_hold", observed(), model(o, f, 0, zero));
        reset = 1'b0;
        $display("[TB] op=%b funct=%b aborted at cycle %0d by reset", o, f, k);
        return;
      end
    end
    $display("[TB] op=%b funct=%b cycles=%0d", o, f, len);
  endtask

  logic [5:0] op_pool [7];
  logic [5:0] fn_pool [5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1;
    op    = 6'b0;
    funct = 6'b0;
    zero  = 1'b0;

    // Outputs while reset is held, across a clock edge.
    #2;
    check("reset_state", observed(), model(6'b0, 6'b0, 0, 1'b0));
    @(posedge clk);
    #1;
    zero = 1'b1;
    #1;
    check("reset_hold", observed(), model(6'b0, 6'b0, 0, 1'b1));
    reset = 1'b0;

    // Directed instructions first.
    run_instr(6'b100011, 6'b000000, -1);
    run_instr(6'b000000, 6'b101010, -1);
    run_instr(6'b000100, 6'b000000, -1);
    run_instr(6'b000101, 6'b000000, -1);
    run_instr(6'b101011, 6'b000000, -1);
    run_instr(6'b111111, 6'b000000, -1);
    run_instr(6'b001000, 6'b000000, -1);
    run_instr(6'b000010, 6'b000000, -1);

    // Reset landing in MEMWR and in ALUWB.
    run_instr(6'b101011, 6'b000000, 3);
    run_instr(6'b100011, 6'b000000, -1);
    run_instr(6'b000000, 6'b100010, 3);
    run_instr(6'b000000, 6'b100100, -1);

    // Random instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] o;
      logic [5:0] f;
      if ($urandom_range(3) == 0) o = 6'($urandom);
      else                        o = op_pool[$urandom_range(6)];
      if ($urandom_range(3) == 0) f = 6'($urandom);
      else                        f = fn_pool[$urandom_range(4)];
      run_instr(o, f, ($urandom_range(19) == 0) ? int'($urandom_range(1)) + 1 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port op, input, 6 bits: instruction opcode from the datapath.
REQ-005 SHALL have port funct, input, 6 bits: R-type function field.
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag from the datapath.
REQ-007 SHALL have outputs pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, each 1 bit: datapath and memory enables and selects.
REQ-008 SHALL have outputs alusrcb and pcsrc, each 2 bits: SrcB select and next-PC select.
REQ-009 SHALL have output alucontrol, 3 bits: ALU function code.

Function
REQ-010 SHALL implement a Moore main FSM with 13 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, BNEBR, ADDIEXEC, ADDIWB, JUMP.
REQ-011 SHALL advance the state on every rising clk; no stalls or waits.
REQ-012 SHALL make these transitions: FETCH->DECODE; MEMADR->MEMRD if op=100011, else MEMWR; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
REQ-013 SHALL return to FETCH from MEMWB, MEMWR, ALUWB, BRANCH, BNEBR, ADDIWB and JUMP.
REQ-014 SHALL decode in DECODE as: 100011 lw or 101011 sw -> MEMADR; 000000 -> EXECUTE; 000100 beq -> BRANCH; 000101 bne -> BNEBR; 001000 addi -> ADDIEXEC; 000010 j -> JUMP.
REQ-015 SHALL go DECODE->FETCH for any other opcode: no register or memory write, instruction dropped; an unreachable state encoding also goes to FETCH.
REQ-016 SHALL drive the state-specific outputs below; every output not listed for a state is 0.
REQ-017 SHALL in FETCH drive iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
REQ-018 SHALL in DECODE drive alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
REQ-019 SHALL drive alusrca=1, alusrcb=10, aluop=00 in both MEMADR and ADDIEXEC.
REQ-020 SHALL drive iord=1 in MEMRD; iord=1, memwrite=1 in MEMWR; regdst=0, memtoreg=1, regwrite=1 in MEMWB.
REQ-021 SHALL in EXECUTE drive alusrca=1, alusrcb=00, aluop=10; in ALUWB drive regdst=1, memtoreg=0, regwrite=1; in ADDIWB drive regdst=0, memtoreg=0, regwrite=1.
REQ-022 SHALL in BRANCH drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; BNEBR is identical but with bne=1 in place of branch.
REQ-023 SHALL in JUMP drive pcsrc=10, pcwrite=1.
REQ-024 SHALL compute pcen = pcwrite | (branch & zero) | (bne & ~zero), combinationally from state and zero.
REQ-025 SHALL hold aluop (2 bits) internal and decode alucontrol combinationally: aluop 00 -> 010; 01 -> 110; 10 -> from funct; 11 -> 010.
REQ-026 SHALL decode funct for aluop 10 as: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other -> 010.
REQ-027 SHALL give each instruction this latency in cycles from FETCH: beq/bne/j 3, R-type/addi/sw 4, lw 5.

Reset
REQ-028 SHALL force state to FETCH immediately on reset assertion, independent of clk.
REQ-029 SHALL, while reset is high, drive the FETCH outputs: pcen=1, irwrite=1, alusrcb=01, alucontrol=010, all other outputs 0.
REQ-030 SHALL, on reset asserted mid-instruction (e.g., in MEMWR or ALUWB), drop the in-progress write that cycle, since outputs become FETCH values at once.
REQ-031 SHALL leave FETCH->DECODE on the first rising clk after reset deasserts.

Verification
REQ-032 Reset then op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; iord=1 in MEMRD, regwrite=1 and memtoreg=1 in MEMWB only.
REQ-033 op=000000, funct=101010 -> in EXECUTE alucontrol=111, alusrca=1, alusrcb=00; in ALUWB regdst=1, regwrite=1; back in FETCH after 4 cycles.
REQ-034 op=000100: zero=1 in BRANCH -> pcen=1, pcsrc=01; zero=0 -> pcen=0. op=000101 (bne) -> the reverse.
REQ-035 op=101011 -> memwrite=1, iord=1 for exactly one cycle in MEMWR; regwrite stays 0 throughout.
REQ-036 op=111111 -> FETCH, DECODE, FETCH; no regwrite, memwrite or extra pcen pulse.
REQ-037 Reset asserted mid-cycle in MEMWR -> memwrite falls to 0 and pcen/irwrite rise to 1 before the next clk edge; state is FETCH.
